// File: rtl/gpio_port_pkg.sv
// Shared constants for the GPIO port: APB word indices and bus width.
package gpio_port_pkg;

  localparam int BUS_W = 32;

  localparam logic [2:0] IDX_DOUT     = 3'd0;
  localparam logic [2:0] IDX_DIR      = 3'd1;
  localparam logic [2:0] IDX_DIN      = 3'd2;
  localparam logic [2:0] IDX_ALTEN    = 3'd3;
  localparam logic [2:0] IDX_RISE_EN  = 3'd4;
  localparam logic [2:0] IDX_FALL_EN  = 3'd5;
  localparam logic [2:0] IDX_ISTAT    = 3'd6;
  localparam logic [2:0] IDX_UNMAPPED = 3'd7;

endpackage

// File: rtl/gpio_sync.sv
// Reset-cleared multi-flop synchronizer for the raw pad inputs.
module gpio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  // Stage 0 samples the pad; the highest stage is the metastability-safe output.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_stage <= '0;
    else     r_stage <= {r_stage[SYNC_STAGES-2:0], i_async};
  end

  assign o_sync = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_port.sv
// APB GPIO port: output/direction registers, alternate-function muxing,
// synchronized inputs and edge interrupts with a post-reset arm window.
module gpio_port
  import gpio_port_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [4:0]       paddr,
  input  logic [BUS_W-1:0] pwdata,
  output logic [BUS_W-1:0] prdata,
  output logic             pready,
  output logic             pslverr,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  input  logic [WIDTH-1:0] alt_out,
  input  logic [WIDTH-1:0] alt_oe,
  output logic [WIDTH-1:0] alt_in,
  output logic             irq
);

  localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] r_dout, r_dir, r_alten, r_rise_en, r_fall_en, r_istat, r_sync_d;
  logic             r_irq;
  logic [2:0]       r_arm;

  logic [WIDTH-1:0] w_sync, w_wdata, w_rise, w_fall, w_set, w_clr, w_rsel;
  logic             w_wr, w_rd, w_armed, w_unused_bits;
  logic [2:0]       w_idx;

  gpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (pin_in),
    .o_sync  (w_sync)
  );

  assign w_idx         = paddr[4:2];
  assign w_wr          = psel & penable & pwrite;
  assign w_rd          = psel & penable & ~pwrite;
  assign w_wdata       = pwdata[WIDTH-1:0];
  assign w_unused_bits = ^{paddr[1:0], pwdata};

  // Edges are ignored until the synchronizer and delay flops have refilled after reset.
  assign w_armed = (r_arm == ARM_DONE);
  assign w_rise  = w_sync & ~r_sync_d;
  assign w_fall  = ~w_sync & r_sync_d;
  assign w_set   = w_armed ? ((w_rise & r_rise_en) | (w_fall & r_fall_en)) : '0;
  assign w_clr   = (w_wr && w_idx == IDX_ISTAT) ? w_wdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout    <= '0;
      r_dir     <= '0;
      r_alten   <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_istat   <= '0;
      r_sync_d  <= '0;
      r_irq     <= 1'b0;
      r_arm     <= '0;
    end else begin
      if (w_wr) begin
        case (w_idx)
          IDX_DOUT:    r_dout    <= w_wdata;
          IDX_DIR:     r_dir     <= w_wdata;
          IDX_ALTEN:   r_alten   <= w_wdata;
          IDX_RISE_EN: r_rise_en <= w_wdata;
          IDX_FALL_EN: r_fall_en <= w_wdata;
          default: ;
        endcase
      end
      // A new edge outranks a same-cycle W1C of that bit.
      r_istat  <= (r_istat & ~w_clr) | w_set;
      r_irq    <= |r_istat;
      r_sync_d <= w_sync;
      if (!w_armed) r_arm <= r_arm + 3'd1;
    end
  end

  always_comb begin
    w_rsel = '0;
    case (w_idx)
      IDX_DOUT:    w_rsel = r_dout;
      IDX_DIR:     w_rsel = r_dir;
      IDX_DIN:     w_rsel = w_sync;
      IDX_ALTEN:   w_rsel = r_alten;
      IDX_RISE_EN: w_rsel = r_rise_en;
      IDX_FALL_EN: w_rsel = r_fall_en;
      IDX_ISTAT:   w_rsel = r_istat;
      default:     w_rsel = '0;
    endcase
    prdata = '0;
    if (w_rd && !rst) prdata[WIDTH-1:0] = w_rsel;
  end

  assign pready  = 1'b1;
  assign pslverr = psel & penable & ~rst & (w_idx == IDX_UNMAPPED);
  assign pin_out = (r_alten & alt_out) | (~r_alten & r_dout);
  assign pin_oe  = (r_alten & alt_oe) | (~r_alten & r_dir);
  assign alt_in  = w_sync;
  assign irq     = r_irq;

endmodule

// File: tb/tb_gpio_port.sv
// Self-checking bench for gpio_port: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model of the register map.
module tb_gpio_port;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         psel, penable, pwrite;
  logic [4:0]   paddr;
  logic [31:0]  pwdata, prdata;
  logic         pready, pslverr;
  logic [W-1:0] pin_in, pin_out, pin_oe, alt_out, alt_oe, alt_in;
  logic         irq;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: the design sees each pad value S cycles late.
  logic [W-1:0] m_dout, m_dir, m_alten, m_rise, m_fall, m_istat, m_din;
  logic         m_irq;
  int           m_cycle;
  logic [W-1:0] hist[$];
  logic [31:0]  exp_q[$];

  gpio_port #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe),
    .alt_out(alt_out), .alt_oe(alt_oe), .alt_in(alt_in), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_dout = '0; m_dir = '0; m_alten = '0; m_rise = '0; m_fall = '0;
    m_istat = '0; m_din = '0; m_irq = 1'b0; m_cycle = 0;
    hist.delete();
    for (int i = 0; i < S + 2; i++) hist.push_back('0);
  endtask

  task automatic model_edge();
    logic [W-1:0] rise, fall, set, clr, wd;
    m_cycle++;
    hist.push_front(pin_in);
    if (hist.size() > S + 2) void'(hist.pop_back());
    rise = hist[S] & ~hist[S+1];
    fall = ~hist[S] & hist[S+1];
    set  = (m_cycle >= S + 2) ? ((rise & m_rise) | (fall & m_fall)) : '0;
    clr  = '0;
    wd   = pwdata[W-1:0];
    if (psel && penable && pwrite) begin
      case (paddr[4:2])
        3'd0: m_dout  = wd;
        3'd1: m_dir   = wd;
        3'd3: m_alten = wd;
        3'd4: m_rise  = wd;
        3'd5: m_fall  = wd;
        3'd6: clr     = wd;
        default: ;
      endcase
    end
    m_irq   = |m_istat;
    m_istat = (m_istat & ~clr) | set;
    m_din   = hist[S-1];
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] idx);
    logic [31:0] v;
    v = '0;
    case (idx)
      3'd0: v[W-1:0] = m_dout;
      3'd1: v[W-1:0] = m_dir;
      3'd2: v[W-1:0] = m_din;
      3'd3: v[W-1:0] = m_alten;
      3'd4: v[W-1:0] = m_rise;
      3'd5: v[W-1:0] = m_fall;
      3'd6: v[W-1:0] = m_istat;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic apb_write(input logic [2:0] idx, input logic [31:0] data);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {idx, 2'b00}; pwdata = data;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] idx, output logic [31:0] data, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {idx, 2'b00};
    tick();
    penable = 1'b1;
    #1;
    data = prdata;
    err  = pslverr;
    exp_q.push_back(model_read(idx));
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd, e;
    logic err;
    rst = 1'b1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 5'd28; pwdata = '0;
    pin_in = '1; alt_out = '1; alt_oe = '1;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_total++; if (pslverr !== 1'b0) $display("FAIL rst_pslverr: got %b want 0", pslverr); else n_pass++;
    n_total++; if (prdata !== 32'h0) $display("FAIL rst_prdata: got %h want 0", prdata); else n_pass++;
    n_total++; if (pin_oe !== 8'h00) $display("FAIL rst_pin_oe: got %h want 00", pin_oe); else n_pass++;
    n_total++; if (pin_out !== 8'h00) $display("FAIL rst_pin_out: got %h want 00", pin_out); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL rst_irq: got %b want 0", irq); else n_pass++;
    n_total++; if (pready !== 1'b1) $display("FAIL rst_pready: got %b want 1", pready); else n_pass++;
    pin_in = '0; alt_out = '0; alt_oe = '0;
    do_reset();
    apb_read(3'd6, rd, err);
    e = exp_q.pop_front();
    n_total++; if (rd !== 32'h0 || rd !== e) $display("FAIL rst_istat: got %h want %h", rd, e); else n_pass++;
  endtask

  task automatic test_dout_dir();
    logic [31:0] rd, e;
    logic err;
    apb_write(3'd1, 32'h0F);
    apb_write(3'd0, 32'hA5);
    n_total++; if (pin_oe !== 8'h0F) $display("FAIL dir_pin_oe: got %h want 0F", pin_oe); else n_pass++;
    n_total++; if (pin_out !== 8'hA5) $display("FAIL dout_pin_out: got %h want A5", pin_out); else n_pass++;
    apb_read(3'd0, rd, err);
    e = exp_q.pop_front();
    n_total++; if (rd !== 32'h000000A5 || rd !== e) $display("FAIL dout_read: got %h want 000000A5", rd); else n_pass++;
    apb_write(3'd2, 32'hFF);
    apb_read(3'd2, rd, err);
    e = exp_q.pop_front();
    n_total++; if (rd !== 32'h0 || rd !== e) $display("FAIL din_write_ignored: got %h want %h", rd, e); else n_pass++;
  endtask

  task automatic test_alt();
    apb_write(3'd0, 32'hA4);
    apb_write(3'd3, 32'h01);
    alt_out = 8'h01; alt_oe = 8'h01;
    #1;
    n_total++; if (pin_out !== 8'hA5) $display("FAIL alt_pin_out: got %h want A5", pin_out); else n_pass++;
    n_total++; if (pin_oe[0] !== 1'b1) $display("FAIL alt_pin_oe0: got %b want 1", pin_oe[0]); else n_pass++;
    alt_oe = 8'h00;
    #1;
    n_total++; if (pin_oe !== 8'h0E) $display("FAIL alt_oe_follow: got %h want 0E", pin_oe); else n_pass++;
    apb_write(3'd3, 32'h00);
    n_total++; if (pin_out !== 8'hA4) $display("FAIL alt_restore_out: got %h want A4", pin_out); else n_pass++;
    n_total++; if (pin_oe !== 8'h0F) $display("FAIL alt_restore_oe: got %h want 0F", pin_oe); else n_pass++;
    alt_out = '0;
  endtask

  task automatic test_rise_irq();
    logic [31:0] rd, e;
    logic err;
    apb_write(3'd4, 32'h04);
    repeat (3) tick();
    pin_in = 8'h04;
    tick();
    n_total++; if (alt_in[2] !== 1'b0) $display("FAIL rise_din_1cyc: got %b want 0", alt_in[2]); else n_pass++;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {3'd6, 2'b00};
    tick();
    n_total++; if (alt_in[2] !== 1'b1) $display("FAIL rise_din_2cyc: got %b want 1", alt_in[2]); else n_pass++;
    tick();
    penable = 1'b1;
    #1;
    n_total++; if (prdata !== 32'h04) $display("FAIL rise_istat_3cyc: got %h want 00000004", prdata); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL rise_irq_3cyc: got %b want 0", irq); else n_pass++;
    tick();
    psel = 1'b0; penable = 1'b0;
    n_total++; if (irq !== 1'b1) $display("FAIL rise_irq_4cyc: got %b want 1", irq); else n_pass++;
    apb_write(3'd6, 32'h04);
    n_total++; if (irq !== 1'b1) $display("FAIL w1c_irq_same: got %b want 1", irq); else n_pass++;
    tick();
    n_total++; if (irq !== 1'b0) $display("FAIL w1c_irq_next: got %b want 0", irq); else n_pass++;
    apb_read(3'd6, rd, err);
    e = exp_q.pop_front();
    n_total++; if (rd !== 32'h0 || rd !== e) $display("FAIL w1c_istat: got %h want 0", rd); else n_pass++;
  endtask

  task automatic test_static_high();
    logic [31:0] rd, e;
    logic err;
    pin_in = 8'hFF;
    do_reset();
    apb_write(3'd4, 32'hFF);
    apb_write(3'd5, 32'hFF);
    repeat (6) tick();
    n_total++; if (irq !== 1'b0) $display("FAIL static_irq: got %b want 0", irq); else n_pass++;
    n_total++; if (alt_in !== 8'hFF) $display("FAIL static_din: got %h want FF", alt_in); else n_pass++;
    apb_read(3'd6, rd, err);
    e = exp_q.pop_front();
    n_total++; if (rd !== 32'h0 || rd !== e) $display("FAIL static_istat: got %h want 0", rd); else n_pass++;
  endtask

  task automatic test_set_wins();
    logic [31:0] rd, e;
    logic err;
    apb_write(3'd4, 32'h00);
    apb_write(3'd5, 32'h02);
    apb_write(3'd6, 32'hFF);
    pin_in = 8'hFD;
    tick();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {3'd6, 2'b00}; pwdata = 32'h02;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    apb_read(3'd6, rd, err);
    e = exp_q.pop_front();
    n_total++; if (rd !== 32'h02 || rd !== e) $display("FAIL set_wins_istat: got %h want 00000002", rd); else n_pass++;
    apb_write(3'd6, 32'h02);
    apb_read(3'd6, rd, err);
    e = exp_q.pop_front();
    n_total++; if (rd !== 32'h0 || rd !== e) $display("FAIL plain_clear: got %h want 0", rd); else n_pass++;
    apb_read(3'd7, rd, err);
    e = exp_q.pop_front();
    n_total++; if (err !== 1'b1) $display("FAIL unmapped_err: got %b want 1", err); else n_pass++;
    n_total++; if (rd !== 32'h0 || rd !== e) $display("FAIL unmapped_rd: got %h want 0", rd); else n_pass++;
    apb_write(3'd7, 32'hFFFFFFFF);
    apb_read(3'd5, rd, err);
    e = exp_q.pop_front();
    n_total++; if (rd !== 32'h02 || rd !== e) $display("FAIL unmapped_wr_fall: got %h want 00000002", rd); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL mapped_err: got %b want 0", err); else n_pass++;
  endtask

  task automatic test_reset_midtransfer();
    logic [31:0] rd, e;
    logic err;
    pin_in = 8'hFF;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {3'd0, 2'b00}; pwdata = 32'h5A;
    tick();
    penable = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    n_total++; if (pin_oe !== 8'h00) $display("FAIL mid_rst_oe: got %h want 00", pin_oe); else n_pass++;
    do_reset();
    apb_read(3'd0, rd, err);
    e = exp_q.pop_front();
    n_total++; if (rd !== 32'h0 || rd !== e) $display("FAIL mid_rst_dout: got %h want 0", rd); else n_pass++;
    apb_write(3'd4, 32'hFF);
    repeat (4) tick();
    n_total++; if (irq !== 1'b0) $display("FAIL mid_rst_arm_irq: got %b want 0", irq); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] rd, e, data;
    logic [2:0]  idx;
    logic        err;
    int          op;
    for (int it = 0; it < 300; it++) begin
      pin_in  = W'($urandom);
      alt_out = W'($urandom);
      alt_oe  = W'($urandom);
      op   = $urandom_range(0, 2);
      idx  = 3'($urandom_range(0, 7));
      data = $urandom;
      if (op == 0) tick();
      else if (op == 1) apb_write(idx, data);
      else begin
        apb_read(idx, rd, err);
        e = exp_q.pop_front();
        n_total++; if (rd !== e) $display("FAIL rnd_read[%0d] idx %0d: got %h want %h", it, idx, rd, e); else n_pass++;
        n_total++; if (err !== (idx == 3'd7)) $display("FAIL rnd_err[%0d]: got %b want %b", it, err, idx == 3'd7); else n_pass++;
      end
      n_total++; if (pin_out !== ((m_alten & alt_out) | (~m_alten & m_dout)))
        $display("FAIL rnd_pin_out[%0d]: got %h want %h", it, pin_out, (m_alten & alt_out) | (~m_alten & m_dout)); else n_pass++;
      n_total++; if (pin_oe !== ((m_alten & alt_oe) | (~m_alten & m_dir)))
        $display("FAIL rnd_pin_oe[%0d]: got %h want %h", it, pin_oe, (m_alten & alt_oe) | (~m_alten & m_dir)); else n_pass++;
      n_total++; if (alt_in !== m_din) $display("FAIL rnd_alt_in[%0d]: got %h want %h", it, alt_in, m_din); else n_pass++;
      n_total++; if (irq !== m_irq) $display("FAIL rnd_irq[%0d]: got %b want %b", it, irq, m_irq); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    pin_in = '0; alt_out = '0; alt_oe = '0;
    model_reset();
    test_reset();
    test_dout_dir();
    test_alt();
    test_rise_irq();
    test_static_high();
    test_set_wins();
    test_reset_midtransfer();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gpio_port.md
GPIO_PORT -- requirements
Module: gpio_port

Interface
REQ-001 Parameter WIDTH, default 8: number of pins, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: input synchronizer depth, legal range 2..4.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 psel, penable, pwrite  in  1 each  APB control.
REQ-006 paddr  in  5  byte address; word index paddr[4:2]; paddr[1:0] ignored.
REQ-007 pwdata  in  32  APB write data.
REQ-008 prdata  out  32  APB read data.
REQ-009 pready  out  1  always 1; zero-wait transfers.
REQ-010 pslverr  out  1  error flag for an unmapped word index.
REQ-011 pin_in  in  WIDTH  raw asynchronous pad inputs.
REQ-012 pin_out, pin_oe  out  WIDTH each  pad drive value and enable; the tristate buffer lives at the top level.
REQ-013 alt_out, alt_oe  in  WIDTH each  alternate-function drive (UART TX, etc.).
REQ-014 alt_in  out  WIDTH  synchronized pin value presented to the alternate function.
REQ-015 irq  out  1  level interrupt.

Function
REQ-016 Register map (word index):
- 0 DOUT RW
- 1 DIR RW, 1=output
- 2 DIN RO, synchronized pins
- 3 ALTEN RW
- 4 RISE_EN RW
- 5 FALL_EN RW
- 6 ISTAT W1C
- 7 unmapped
REQ-017 A write commits on the clk edge where psel&penable&pwrite=1, using pwdata[WIDTH-1:0]; writes to DIN are ignored.
REQ-018 prdata shall be combinational from the register state while psel&penable&!pwrite, with bits [31:WIDTH]=0; otherwise prdata=0.
REQ-019 Word index 7 shall assert pslverr during the access phase, read as 0, and its writes shall have no effect.
REQ-020 Per pin i, pin_out[i] = ALTEN[i] ? alt_out[i] : DOUT[i].
REQ-021 Per pin i, pin_oe[i] = ALTEN[i] ? alt_oe[i] : DIR[i].
REQ-022 pin_in shall pass through a SYNC_STAGES-flop synchronizer.
REQ-023 DIN and alt_in equal the synchronizer output, so a pad change is visible SYNC_STAGES cycles later.
REQ-024 Edge detection compares the synchronizer output with a one-cycle-delayed copy, for every pin regardless of DIR or ALTEN.
REQ-025 A rising edge with RISE_EN[i]=1, or a falling edge with FALL_EN[i]=1, shall set ISTAT[i] on the following clk edge.
REQ-026 Edges on disabled pins never set ISTAT; enabling an edge type later shall not retroactively set ISTAT.
REQ-027 An ISTAT write clears every bit written as 1 and leaves bits written as 0 unchanged.
REQ-028 If a set and a clear hit the same ISTAT bit in the same cycle, the set wins.
REQ-029 irq shall be registered: irq = |ISTAT, one cycle after ISTAT changes.
REQ-030 An arm counter shall suppress edge detection for SYNC_STAGES+1 cycles after reset release, so pins that are static-high at reset do not raise false edges.

Reset
REQ-031 On rst, all of the following clear to 0:
- DOUT, DIR, ALTEN, RISE_EN, FALL_EN, ISTAT
- synchronizer and delay flops
- irq, arm counter
REQ-032 During reset, pin_oe=alt_oe&0=0 (all pads input), pin_out=0, prdata=0, pslverr=0.
REQ-033 A reset asserted mid-transfer aborts the transfer with no register update, and the arm window restarts on release.

Structure
REQ-034 Package gpio_port_pkg holds the word-index constants (DOUT..ISTAT), the unmapped index, and the bus width constant 32.
REQ-035 Sub-module gpio_sync(WIDTH, SYNC_STAGES) implements the reset-cleared synchronizer; edge logic and registers remain in gpio_port.

Verification
REQ-036 Write DIR=0x0F, then DOUT=0xA5 -> pin_oe=0x0F, pin_out=0xA5; read DOUT=0x000000A5.
REQ-037 ALTEN=0x01, alt_out[0]=1, alt_oe[0]=1, DOUT[0]=0 -> pin_out[0]=1, pin_oe[0]=1; clearing ALTEN restores pin_out[0]=0.
REQ-038 RISE_EN=0x04, pin_in[2] 0->1 -> DIN[2]=1 after 2 cycles, ISTAT=0x04 after 3 cycles, irq=1 after 4 cycles; W1C 0x04 -> irq=0 in the following cycle.
REQ-039 Hold pin_in=0xFF through reset with RISE_EN preloaded after release -> ISTAT stays 0 and irq stays 0.
REQ-040 Arrange a falling edge that sets ISTAT[1] in the same cycle as a W1C of 0x02 -> ISTAT[1]=1 afterwards; a read of index 7 -> pslverr=1, prdata=0.
